// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle radix-2 restoring divider:
// state encoding, iteration count helper and the divide-by-zero constant.
package div_pkg;

    localparam int unsigned DIV_WIDTH     = 32;
    localparam int unsigned DIV_MAX_WIDTH = 64;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_BUSY = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    // Quotient delivered for any divide by zero, sliced to the operand width.
    localparam logic [DIV_MAX_WIDTH-1:0] DIV_BY_ZERO_QUO = {DIV_MAX_WIDTH{1'b1}};

    typedef struct packed {
        logic neg_quo;
        logic neg_rem;
    } div_sign_t;

    function automatic int unsigned div_cycles(input int unsigned width);
        return width;
    endfunction

    localparam int unsigned DIV_CYCLES = div_cycles(DIV_WIDTH);

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift {rem, quo} left by one,
// then subtract the divisor and set the quotient LSB when it fits.
module div_step
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_dvs,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH+1:0] w_shift;
    logic [WIDTH-1:0] w_diff;
    logic             w_ge;

    // Trial subtraction; a partial remainder below the divisor always fits in WIDTH bits.
    always_comb begin
        w_shift = {i_rem, i_quo[WIDTH-1]};
        w_ge    = (w_shift >= {2'b00, i_dvs});
        w_diff  = w_shift[WIDTH-1:0] - i_dvs;
        if (w_ge) begin
            o_rem = w_diff;
            o_quo = {i_quo[WIDTH-2:0], 1'b1};
        end else begin
            o_rem = w_shift[WIDTH-1:0];
            o_quo = {i_quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_unit.sv
// DIV/DIVU execute-stage divider: latches operand magnitudes, iterates one
// restoring step per cycle, applies sign fix-up and pulses ready with {HI, LO}.
module div_unit
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_signed_div,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    input  logic               i_annul,
    output logic               o_stall,
    output logic               o_ready,
    output logic [2*WIDTH-1:0] o_result
);

    localparam int unsigned     CW        = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]   LAST_STEP = CW'(div_cycles(WIDTH) - 1);
    localparam logic [WIDTH-1:0] DZ_QUO   = DIV_BY_ZERO_QUO[WIDTH-1:0];

    logic [1:0]           r_state;
    logic [CW-1:0]        r_count;
    logic [WIDTH:0]       r_rem;
    logic [WIDTH-1:0]     r_quo;
    logic [WIDTH-1:0]     r_dvs;
    div_sign_t            r_sign;
    logic [2*WIDTH-1:0]   r_result;

    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH-1:0]     w_a_abs;
    logic [WIDTH-1:0]     w_b_abs;
    logic                 w_b_zero;
    logic [WIDTH-1:0]     w_rem_nxt;
    logic [WIDTH-1:0]     w_quo_nxt;
    logic [WIDTH-1:0]     w_rem_fix;
    logic [WIDTH-1:0]     w_quo_fix;

    // Operand magnitudes; the most negative value maps onto itself read as unsigned.
    always_comb begin
        w_a_neg  = i_signed_div & i_a[WIDTH-1];
        w_b_neg  = i_signed_div & i_b[WIDTH-1];
        w_a_abs  = w_a_neg ? ({WIDTH{1'b0}} - i_a) : i_a;
        w_b_abs  = w_b_neg ? ({WIDTH{1'b0}} - i_b) : i_b;
        w_b_zero = (i_b == {WIDTH{1'b0}});
    end

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_dvs (r_dvs),
        .o_rem (w_rem_nxt),
        .o_quo (w_quo_nxt)
    );

    // Sign fix-up of the final step: quotient by sign mismatch, remainder follows the dividend.
    always_comb begin
        w_quo_fix = r_sign.neg_quo ? ({WIDTH{1'b0}} - w_quo_nxt) : w_quo_nxt;
        w_rem_fix = r_sign.neg_rem ? ({WIDTH{1'b0}} - w_rem_nxt) : w_rem_nxt;
    end

    // FSM, iteration counter, datapath registers and result register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_count  <= {CW{1'b0}};
            r_rem    <= {(WIDTH+1){1'b0}};
            r_quo    <= {WIDTH{1'b0}};
            r_dvs    <= {WIDTH{1'b0}};
            r_sign   <= '{neg_quo: 1'b0, neg_rem: 1'b0};
            r_result <= {(2*WIDTH){1'b0}};
        end else if (i_annul) begin
            r_state <= ST_IDLE;
            r_count <= {CW{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start && w_b_zero) begin
                        r_result <= {i_a, DZ_QUO};
                        r_state  <= ST_DONE;
                    end else if (i_start) begin
                        r_rem          <= {(WIDTH+1){1'b0}};
                        r_quo          <= w_a_abs;
                        r_dvs          <= w_b_abs;
                        r_sign.neg_quo <= w_a_neg ^ w_b_neg;
                        r_sign.neg_rem <= w_a_neg;
                        r_count        <= {CW{1'b0}};
                        r_state        <= ST_BUSY;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    r_rem <= {1'b0, w_rem_nxt};
                    r_quo <= w_quo_nxt;
                    // The last step lands straight in the result so it is valid during DONE.
                    if (r_count == LAST_STEP) begin
                        r_result <= {w_rem_fix, w_quo_fix};
                        r_count  <= {CW{1'b0}};
                        r_state  <= ST_DONE;
                    end else begin
                        r_count <= r_count + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_count <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign o_stall  = !i_rst && !i_annul &&
                      (((r_state == ST_IDLE) && i_start) || (r_state == ST_BUSY));
    assign o_ready  = (r_state == ST_DONE) && !i_rst && !i_annul;
    assign o_result = r_result;

endmodule

// File: tb/tb_div_unit.sv
// Directed, table-driven bench for div_unit with hand-written abort and
// back-to-back sequences.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        annul;
    logic        stall;
    logic        ready;
    logic [63:0] result;

    int n_checks = 0;
    int n_errors = 0;

    div_unit #(.WIDTH(32)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_signed_div (signed_div),
        .i_a          (a_in),
        .i_b          (b_in),
        .i_annul      (annul),
        .o_stall      (stall),
        .o_ready      (ready),
        .o_result     (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        sg;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp_res;
        int          exp_lat;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Cycle 0 starts at posedge+1; outputs sampled on the following negedge.
    task automatic run_op(input logic sg, input logic [31:0] a, input logic [31:0] b,
                          output int rdy_cyc, output int rdy_cnt, output int stall_cnt,
                          output logic [63:0] res);
        rdy_cyc = -1; rdy_cnt = 0; stall_cnt = 0; res = 64'h0;
        @(posedge clk); #1;
        start = 1'b1; signed_div = sg; a_in = a; b_in = b;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            if (stall) stall_cnt++;
            if (ready) begin
                rdy_cnt++;
                if (rdy_cyc < 0) begin
                    rdy_cyc = c;
                    res = result;
                end
            end
            @(posedge clk); #1;
            start = 1'b0; signed_div = ~sg; a_in = ~a; b_in = 32'h0;
        end
    endtask

    vec_t        tbl[13];
    int          rc, rn, sc;
    logic [63:0] rr;
    int          cnt_r, cnt_s;

    initial begin
        tbl[0]  = '{"divu_100_7",   1'b0, 32'd100,       32'd7,        {32'h0000_0002, 32'h0000_000E}, 33};
        tbl[1]  = '{"div_m7_2",     1'b1, 32'hFFFF_FFF9, 32'd2,        {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33};
        tbl[2]  = '{"div_7_m2",     1'b1, 32'd7,         32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 33};
        tbl[3]  = '{"div_ovf",      1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}, 33};
        tbl[4]  = '{"divu_ovf",     1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'h0000_0000}, 33};
        tbl[5]  = '{"divu_dz",      1'b0, 32'h1234_5678, 32'h0,        {32'h1234_5678, 32'hFFFF_FFFF}, 1};
        tbl[6]  = '{"div_dz",       1'b1, 32'h1234_5678, 32'h0,        {32'h1234_5678, 32'hFFFF_FFFF}, 1};
        tbl[7]  = '{"divu_max_1",   1'b0, 32'hFFFF_FFFF, 32'd1,        {32'h0000_0000, 32'hFFFF_FFFF}, 33};
        tbl[8]  = '{"div_m100_m7",  1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, {32'hFFFF_FFFE, 32'h0000_000E}, 33};
        tbl[9]  = '{"divu_5_9",     1'b0, 32'd5,         32'd9,        {32'h0000_0005, 32'h0000_0000}, 33};
        tbl[10] = '{"divu_max_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'h0000_0000, 32'h0000_0001}, 33};
        tbl[11] = '{"div_min_2",    1'b1, 32'h8000_0000, 32'd2,        {32'h0000_0000, 32'hC000_0000}, 33};
        tbl[12] = '{"divu_dead_16", 1'b0, 32'hDEAD_BEEF, 32'h10,       {32'h0000_000F, 32'h0DEA_DBEE}, 33};

        rst = 1'b1; start = 1'b1; signed_div = 1'b0; a_in = 32'd5; b_in = 32'd1; annul = 1'b0;
        @(negedge clk);
        chk("reset_stall",  {63'h0, stall}, 64'h0);
        chk("reset_ready",  {63'h0, ready}, 64'h0);
        chk("reset_result", result, 64'h0);
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;

        for (int i = 0; i < 13; i++) begin
            run_op(tbl[i].sg, tbl[i].a, tbl[i].b, rc, rn, sc, rr);
            chk({tbl[i].name, "_result"},  rr, tbl[i].exp_res);
            chk({tbl[i].name, "_latency"}, 64'(rc), 64'(tbl[i].exp_lat));
            chk({tbl[i].name, "_stalls"},  64'(sc), 64'(tbl[i].exp_lat));
            chk({tbl[i].name, "_readies"}, 64'(rn), 64'd1);
        end

        // Annul mid-operation: last good result is 0xDEADBEEF/16.
        @(posedge clk); #1;
        start = 1'b1; signed_div = 1'b0; a_in = 32'd50; b_in = 32'd3;
        cnt_r = 0;
        for (int c = 1; c < 10; c++) begin
            @(posedge clk); #1; start = 1'b0;
            @(negedge clk); if (ready) cnt_r++;
        end
        @(posedge clk); #1; annul = 1'b1;
        @(negedge clk);
        chk("annul_stall_drop", {63'h0, stall}, 64'h0);
        @(posedge clk); #1; annul = 1'b0;
        cnt_s = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ready) cnt_r++;
            if (stall) cnt_s++;
            @(posedge clk); #1;
        end
        chk("annul_no_ready", 64'(cnt_r), 64'd0);
        chk("annul_idle",     64'(cnt_s), 64'd0);
        chk("annul_result_kept", result, {32'h0000_000F, 32'h0DEA_DBEE});

        // Annul overrides a start in the same cycle.
        start = 1'b1; annul = 1'b1; a_in = 32'd9; b_in = 32'd3;
        @(negedge clk);
        chk("annul_start_stall", {63'h0, stall}, 64'h0);
        @(posedge clk); #1; start = 1'b0; annul = 1'b0;
        cnt_r = 0; cnt_s = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ready) cnt_r++;
            if (stall) cnt_s++;
            @(posedge clk); #1;
        end
        chk("annul_start_no_ready", 64'(cnt_r), 64'd0);
        chk("annul_start_no_stall", 64'(cnt_s), 64'd0);

        // Reset at cycle 20, then an immediately following DIVU 9/3.
        start = 1'b1; signed_div = 1'b0; a_in = 32'd50; b_in = 32'd3;
        cnt_r = 0;
        for (int c = 1; c < 20; c++) begin
            @(posedge clk); #1; start = 1'b0;
            @(negedge clk); if (ready) cnt_r++;
        end
        @(posedge clk); #1; rst = 1'b1;
        @(negedge clk);
        chk("rst_stall_drop", {63'h0, stall}, 64'h0);
        if (ready) cnt_r++;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        if (ready) cnt_r++;
        chk("rst_no_ready", 64'(cnt_r), 64'd0);
        chk("rst_result_clear", result, 64'h0);
        run_op(1'b0, 32'd9, 32'd3, rc, rn, sc, rr);
        chk("after_rst_result",  rr, {32'h0, 32'h3});
        chk("after_rst_latency", 64'(rc), 64'd33);

        // Back-to-back: next start in the cycle after DONE.
        @(posedge clk); #1;
        start = 1'b1; signed_div = 1'b0; a_in = 32'd100; b_in = 32'd7;
        cnt_r = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (ready) begin
                cnt_r++;
                if (c == 33) chk("b2b_first_result",  result, {32'h2, 32'hE});
                else if (c == 67) chk("b2b_second_result", result, {32'h0, 32'h3});
                else chk("b2b_ready_cycle", 64'(c), 64'd33);
            end
            @(posedge clk); #1;
            if (c + 1 == 34) begin
                start = 1'b1; a_in = 32'd9; b_in = 32'd3;
            end else if (c + 1 > 34) begin
                start = 1'b0; a_in = 32'h0; b_in = 32'h0;
            end else begin
                start = 1'b1;
            end
        end
        chk("b2b_ready_count", 64'(cnt_r), 64'd2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
